i2c_req_scheduler: RTL and testbench
====================================

I2C_REQ_SCHEDULER -- requirements
Module: i2c_req_scheduler

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NUM_REQ  4  requester count, fixed at 4
  TIMEOUT  1024  clk cycles allowed per transfer before abort
  GAP  8  minimum idle clk cycles between transfers (bus free time)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  system clock, all logic on posedge
  rst  in  1  reset, asynchronous, active-high
  req  in  4  per-requester transfer request, level, held until done/err
  req_addr  in  28  7-bit slave address per requester, requester i at [7i+6:7i]
  req_rw  in  4  per-requester direction, 1=read, 0=write
  req_wdata  in  32  write byte per requester, requester i at [8i+7:8i]
  gnt  out  4  one-hot grant, high for the whole owned transfer
  done  out  4  one-cycle completion pulse to the owner
  err  out  4  one-cycle timeout-abort pulse to the owner
  rdata  out  8  read byte, valid in the cycle done pulses for a read
  m_enable  out  1  enable to the shared I2C master
  m_addr  out  7  address to the master
  m_rw  out  1  direction to the master
  m_data_in  out  8  write byte to the master
  m_ready  in  1  master idle flag, high when master is in IDLE
  m_data_out  in  8  read byte from the master
  bus_busy  in  1  external bus-activity indication
  m_lines_busy  out  1  lines_busy to the master

Function
REQ-003 FSM states SHALL be IDLE, GAP_WAIT, ARB, LAUNCH, BUSY, FINISH.
REQ-004 IDLE: when any req is high and bus_busy is low, the next state SHALL be ARB; otherwise the FSM stays in IDLE.
REQ-005 ARB SHALL be one cycle: grant the first requesting index after last_gnt in round-robin order (last_gnt resets to 3, so index 0 wins first), register gnt one-hot, update last_gnt, go to LAUNCH.
REQ-006 Grant latency: gnt asserts in the second cycle after req is first sampled high in IDLE.
REQ-007 If all reqs drop before ARB evaluates, ARB SHALL return to IDLE with gnt=0.
REQ-008 m_addr, m_rw, m_data_in SHALL be muxed from the granted requester's fields and be 0 when gnt=0.
REQ-009 LAUNCH: m_enable=1 until m_ready is sampled low, then go to BUSY with m_enable=0, which makes the master perform exactly one byte and then STOP.
REQ-010 BUSY: wait for m_ready to be sampled high again, then go to FINISH.
REQ-011 FINISH SHALL be one cycle: pulse done[owner]=1, load rdata with m_data_out if m_rw=1 (otherwise hold rdata), clear gnt, load the gap counter with GAP, go to GAP_WAIT.
REQ-012 GAP_WAIT SHALL decrement the gap counter each cycle and go to IDLE when it reaches 0, giving exactly GAP idle cycles.
REQ-013 A 16-bit timeout counter SHALL clear on entry to LAUNCH and increment in LAUNCH/BUSY.
REQ-014 When the timeout counter reaches TIMEOUT-1 in LAUNCH or BUSY: pulse err[owner], drive m_enable=0, clear gnt, go to GAP_WAIT; done SHALL NOT pulse.
REQ-015 m_lines_busy SHALL equal bus_busy OR (state != IDLE).
REQ-016 A requester that drops req while granted SHALL NOT abort the transfer; done still pulses to it.
REQ-017 A requester may re-raise req immediately after done; round-robin SHALL still prefer other pending requesters.
REQ-018 done and err SHALL never both be high, and at most one bit of each SHALL be high.
REQ-019 req changes during LAUNCH/BUSY SHALL NOT change m_addr, m_rw, m_data_in (fields latched at ARB).

Reset
REQ-020 On rst: state=IDLE; gnt, done, err, rdata=0; m_enable=0; m_addr, m_rw, m_data_in=0; counters=0; last_gnt=3.
REQ-021 rst mid-transfer SHALL return all outputs to reset values immediately (asynchronous) without a done or err pulse.

Verification
REQ-022 Single write: req=0001, addr0=0x50, wdata0=0xA5; the master model drops m_ready for 40 cycles -> gnt=0001, m_addr=0x50, m_rw=0, m_data_in=0xA5, done=0001 one cycle after m_ready rises, then 8 idle cycles.
REQ-023 Contention: req=1111 held -> grant order 0,1,2,3,0, each transfer separated by GAP cycles.
REQ-024 Read: req=0100, rw2=1, master returns 0x3C -> rdata=0x3C in the done[2] cycle.
REQ-025 Timeout: m_ready never falls -> err=0001 at cycle 1023 of LAUNCH, m_enable=0, no done pulse.
REQ-026 bus_busy=1 with req=0010 -> no grant until bus_busy=0; rst asserted during BUSY -> gnt=0 and m_enable=0 immediately.

Source files
------------

// File: rtl/i2c_req_scheduler_if.sv
// Request/grant bundle between four requesters, the scheduler and a shared I2C master.
// The slave modport is the scheduler side; the master modport is the environment side.
interface i2c_req_scheduler_if;
    logic [3:0]  req;
    logic [27:0] req_addr;
    logic [3:0]  req_rw;
    logic [31:0] req_wdata;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [3:0]  err;
    logic [7:0]  rdata;
    logic        m_enable;
    logic [6:0]  m_addr;
    logic        m_rw;
    logic [7:0]  m_data_in;
    logic        m_ready;
    logic [7:0]  m_data_out;
    logic        bus_busy;
    logic        m_lines_busy;

    modport slave (
        input  req, req_addr, req_rw, req_wdata, m_ready, m_data_out, bus_busy,
        output gnt, done, err, rdata, m_enable, m_addr, m_rw, m_data_in, m_lines_busy
    );

    modport master (
        output req, req_addr, req_rw, req_wdata, m_ready, m_data_out, bus_busy,
        input  gnt, done, err, rdata, m_enable, m_addr, m_rw, m_data_in, m_lines_busy
    );
endinterface

// File: rtl/i2c_req_scheduler.sv
// Round-robin scheduler sharing one single-byte I2C master among four requesters,
// with per-transfer timeout abort and an enforced bus-free gap between transfers.
module i2c_req_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned GAP     = 8
) (
    input logic                clk,
    input logic                rst,
    i2c_req_scheduler_if.slave bus
);
    typedef enum logic [2:0] {IDLE, GAP_WAIT, ARB, LAUNCH, BUSY, FINISH} state_e;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0] GAP_LOAD = 16'(GAP);

    state_e      state_q;
    logic [3:0]  gnt_q;
    logic [3:0]  done_q;
    logic [3:0]  err_q;
    logic [7:0]  rdata_q;
    logic        m_enable_q;
    logic [6:0]  m_addr_q;
    logic        m_rw_q;
    logic [7:0]  m_data_in_q;
    logic [1:0]  last_gnt_q;
    logic [15:0] tmo_q;
    logic [15:0] gap_q;

    logic [6:0]  addr_arr  [4];
    logic [7:0]  wdata_arr [4];
    logic        win_valid;
    logic [1:0]  win_idx;
    logic [1:0]  cand;
    logic        tmo_hit;

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            addr_arr[i]  = bus.req_addr[7*i +: 7];
            wdata_arr[i] = bus.req_wdata[8*i +: 8];
        end
        // Search starts one past the previous owner; the 2-bit index wraps naturally.
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = last_gnt_q + 2'(k);
            if (!win_valid && bus.req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign tmo_hit = (tmo_q == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
            m_enable_q  <= 1'b0;
            m_addr_q    <= '0;
            m_rw_q      <= 1'b0;
            m_data_in_q <= '0;
            last_gnt_q  <= 2'd3;
            tmo_q       <= '0;
            gap_q       <= '0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            unique case (state_q)
                IDLE: begin
                    if (|bus.req && !bus.bus_busy) state_q <= ARB;
                end
                ARB: begin
                    if (win_valid) begin
                        gnt_q       <= 4'b0001 << win_idx;
                        last_gnt_q  <= win_idx;
                        m_addr_q    <= addr_arr[win_idx];
                        m_rw_q      <= bus.req_rw[win_idx];
                        m_data_in_q <= wdata_arr[win_idx];
                        m_enable_q  <= 1'b1;
                        tmo_q       <= '0;
                        state_q     <= LAUNCH;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                LAUNCH, BUSY: begin
                    if (tmo_hit) begin
                        err_q       <= 4'b0001 << last_gnt_q;
                        gnt_q       <= '0;
                        m_enable_q  <= 1'b0;
                        m_addr_q    <= '0;
                        m_rw_q      <= 1'b0;
                        m_data_in_q <= '0;
                        gap_q       <= GAP_LOAD;
                        state_q     <= GAP_WAIT;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                        if (state_q == LAUNCH) begin
                            if (!bus.m_ready) begin
                                m_enable_q <= 1'b0;
                                state_q    <= BUSY;
                            end
                        end else if (bus.m_ready) begin
                            // done/rdata registered here so they are visible during FINISH itself
                            done_q <= 4'b0001 << last_gnt_q;
                            if (m_rw_q) rdata_q <= bus.m_data_out;
                            state_q <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    gnt_q       <= '0;
                    m_addr_q    <= '0;
                    m_rw_q      <= 1'b0;
                    m_data_in_q <= '0;
                    gap_q       <= GAP_LOAD;
                    state_q     <= GAP_WAIT;
                end
                GAP_WAIT: begin
                    if (gap_q <= 16'd1) begin
                        gap_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q - 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.rdata        = rdata_q;
    assign bus.m_enable     = m_enable_q;
    assign bus.m_addr       = m_addr_q;
    assign bus.m_rw         = m_rw_q;
    assign bus.m_data_in    = m_data_in_q;
    assign bus.m_lines_busy = bus.bus_busy | (state_q != IDLE);
endmodule

// File: tb/tb_i2c_req_scheduler.sv
// Scenario bench for i2c_req_scheduler: a behavioural I2C master model drives m_ready,
// and a transaction-level round-robin model predicts owners, fields and read data.
module tb_i2c_req_scheduler;
    localparam int TIMEOUT = 1024;
    localparam int GAP     = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    i2c_req_scheduler_if bus();

    i2c_req_scheduler #(.NUM_REQ(4), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    int         master_len   = 5;
    bit         master_dead  = 1'b0;
    logic [7:0] master_rdata = 8'h00;

    int         model_last  = 3;
    logic [7:0] model_rdata = 8'h00;
    logic [6:0] f_addr  [4];
    logic       f_rw    [4];
    logic [7:0] f_wdata [4];

    // Master: takes a job when enabled, holds m_ready low master_len cycles, returns data.
    initial begin
        bus.m_ready    = 1'b1;
        bus.m_data_out = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.m_enable === 1'b1 && !master_dead && rst === 1'b0) begin
                bus.m_ready = 1'b0;
                repeat (master_len) @(negedge clk);
                bus.m_data_out = master_rdata;
                bus.m_ready    = 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    function automatic int rr_pick(input int last, input logic [3:0] mask);
        for (int k = 1; k <= 4; k++) begin
            if (mask[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic randomize_fields();
        for (int i = 0; i < 4; i++) begin
            f_addr[i]  = 7'($urandom);
            f_rw[i]    = 1'($urandom);
            f_wdata[i] = 8'($urandom);
        end
    endtask

    task automatic drive_fields();
        for (int i = 0; i < 4; i++) begin
            bus.req_addr[7*i +: 7]  = f_addr[i];
            bus.req_rw[i]           = f_rw[i];
            bus.req_wdata[8*i +: 8] = f_wdata[i];
        end
    endtask

    // n = samples until gnt nonzero (including that sample), -1 if the bound expires.
    task automatic wait_gnt(input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.gnt === 4'b0000 && n < bound);
        if (bus.gnt === 4'b0000) n = -1;
    endtask

    task automatic wait_done(input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.done === 4'b0000 && bus.err === 4'b0000 && n < bound);
        if (bus.done === 4'b0000 && bus.err === 4'b0000) n = -1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.req      = '0;
        bus.bus_busy = 1'b0;
        repeat (3) @(negedge clk);
        rst         = 1'b0;
        model_last  = 3;
        model_rdata = 8'h00;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.req      = '0;
        bus.bus_busy = 1'b0;
        randomize_fields();
        drive_fields();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.gnt, bus.done, bus.err} !== 12'h000) begin
            errors++; $display("FAIL reset_gnt_done_err: got %h expected 000", {bus.gnt, bus.done, bus.err});
        end
        checks++;
        if (bus.rdata !== 8'h00 || bus.m_enable !== 1'b0) begin
            errors++; $display("FAIL reset_rdata_enable: got %h/%b expected 00/0", bus.rdata, bus.m_enable);
        end
        checks++;
        if ({bus.m_addr, bus.m_rw, bus.m_data_in} !== 16'h0000) begin
            errors++; $display("FAIL reset_master_fields: got %h expected 0000", {bus.m_addr, bus.m_rw, bus.m_data_in});
        end
        bus.bus_busy = 1'b1;
        #1;
        checks++;
        if (bus.m_lines_busy !== 1'b1) begin
            errors++; $display("FAIL reset_lines_busy_ext: got %b expected 1", bus.m_lines_busy);
        end
        bus.bus_busy = 1'b0;
        #1;
        checks++;
        if (bus.m_lines_busy !== 1'b0) begin
            errors++; $display("FAIL reset_lines_busy_idle: got %b expected 0", bus.m_lines_busy);
        end
        @(negedge clk);
        rst         = 1'b0;
        model_last  = 3;
        model_rdata = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        int n;
        bit bad;
        randomize_fields();
        f_addr[0] = 7'h50; f_wdata[0] = 8'hA5; f_rw[0] = 1'b0;
        drive_fields();
        master_len   = 40;
        master_rdata = 8'($urandom);
        bus.req = 4'b0001;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0000 || bus.m_lines_busy !== 1'b1) begin
            errors++; $display("FAIL write_arb_cycle: got gnt=%b lines=%b expected 0000/1", bus.gnt, bus.m_lines_busy);
        end
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0001) begin
            errors++; $display("FAIL write_gnt_latency: got %b expected 0001", bus.gnt);
        end
        checks++;
        if ({bus.m_addr, bus.m_rw, bus.m_data_in} !== {7'h50, 1'b0, 8'hA5} || bus.m_enable !== 1'b1) begin
            errors++; $display("FAIL write_fields: got %h/%b/%h en=%b expected 50/0/a5 en=1",
                               bus.m_addr, bus.m_rw, bus.m_data_in, bus.m_enable);
        end
        model_last = 0;
        wait_done(200, n);
        // Master raises m_ready after master_len samples; the next edge registers done.
        checks++;
        if (n !== master_len + 1) begin
            errors++; $display("FAIL write_done_latency: got %0d expected %0d", n, master_len + 1);
        end
        checks++;
        if (bus.done !== 4'b0001 || bus.err !== 4'b0000 || bus.gnt !== 4'b0001 || bus.rdata !== model_rdata) begin
            errors++; $display("FAIL write_done: got done=%b err=%b gnt=%b rdata=%h expected 0001/0000/0001/%h",
                               bus.done, bus.err, bus.gnt, bus.rdata, model_rdata);
        end
        bus.req = '0;
        bad = 1'b0;
        for (int i = 0; i < GAP + 2; i++) begin
            @(negedge clk);
            if (bus.gnt !== 4'b0000 || bus.done !== 4'b0000 || bus.err !== 4'b0000) bad = 1'b1;
        end
        checks++;
        if (bad || {bus.m_addr, bus.m_rw, bus.m_data_in} !== 16'h0000) begin
            errors++; $display("FAIL write_gap_idle: got bad=%b fields=%h expected 0/0000", bad,
                               {bus.m_addr, bus.m_rw, bus.m_data_in});
        end
    endtask

    task automatic test_req_drop();
        bit bad;
        bus.req = 4'b0010;
        @(negedge clk);
        bus.req = '0;
        checks++;
        if (bus.m_lines_busy !== 1'b1) begin
            errors++; $display("FAIL drop_lines_busy_arb: got %b expected 1", bus.m_lines_busy);
        end
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.gnt !== 4'b0000 || bus.m_enable !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad || bus.m_lines_busy !== 1'b0) begin
            errors++; $display("FAIL drop_no_grant: got bad=%b lines=%b expected 0/0", bad, bus.m_lines_busy);
        end
    endtask

    task automatic test_read();
        int n;
        randomize_fields();
        f_rw[2] = 1'b1; f_rw[1] = 1'b0;
        drive_fields();
        master_len   = $urandom_range(2, 10);
        master_rdata = 8'h3C;
        bus.req = 4'b0100;
        wait_gnt(20, n);
        checks++;
        if (n !== 2 || bus.gnt !== 4'b0100 || bus.m_rw !== 1'b1) begin
            errors++; $display("FAIL read_gnt: got n=%0d gnt=%b rw=%b expected 2/0100/1", n, bus.gnt, bus.m_rw);
        end
        model_last = 2;
        wait_done(100, n);
        checks++;
        if (bus.done !== 4'b0100 || bus.rdata !== 8'h3C) begin
            errors++; $display("FAIL read_rdata: got done=%b rdata=%h expected 0100/3c", bus.done, bus.rdata);
        end
        model_rdata = 8'h3C;
        bus.req = 4'b0010;
        master_rdata = 8'hFF;
        wait_gnt(40, n);
        checks++;
        if (n !== GAP + 3 || bus.gnt !== 4'b0010) begin
            errors++; $display("FAIL read_next_gnt: got n=%0d gnt=%b expected %0d/0010", n, bus.gnt, GAP + 3);
        end
        model_last = 1;
        wait_done(100, n);
        checks++;
        if (bus.done !== 4'b0010 || bus.rdata !== model_rdata) begin
            errors++; $display("FAIL write_holds_rdata: got done=%b rdata=%h expected 0010/%h",
                               bus.done, bus.rdata, model_rdata);
        end
        bus.req = '0;
        repeat (GAP + 3) @(negedge clk);
    endtask

    task automatic test_contention();
        int n;
        int order [5] = '{0, 1, 2, 3, 0};
        logic [7:0] exp_rdata;
        do_reset();
        randomize_fields();
        drive_fields();
        bus.req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            master_len   = $urandom_range(1, 12);
            master_rdata = 8'($urandom);
            wait_gnt(100, n);
            // Between owners: GAP cycles of GAP_WAIT, one IDLE, one ARB, then the grant sample.
            checks++;
            if (n !== ((t == 0) ? 2 : GAP + 3)) begin
                errors++; $display("FAIL contention_spacing[%0d]: got %0d expected %0d", t, n, (t == 0) ? 2 : GAP + 3);
            end
            checks++;
            if (bus.gnt !== (4'b0001 << order[t])) begin
                errors++; $display("FAIL contention_order[%0d]: got %b expected %b", t, bus.gnt, 4'b0001 << order[t]);
            end
            checks++;
            if ({bus.m_addr, bus.m_rw, bus.m_data_in} !== {f_addr[order[t]], f_rw[order[t]], f_wdata[order[t]]}) begin
                errors++; $display("FAIL contention_fields[%0d]: got %h expected %h", t,
                                   {bus.m_addr, bus.m_rw, bus.m_data_in},
                                   {f_addr[order[t]], f_rw[order[t]], f_wdata[order[t]]});
            end
            model_last = order[t];
            wait_done(100, n);
            exp_rdata = f_rw[order[t]] ? master_rdata : model_rdata;
            checks++;
            if (n !== master_len + 1 || bus.done !== (4'b0001 << order[t]) || bus.rdata !== exp_rdata) begin
                errors++; $display("FAIL contention_done[%0d]: got n=%0d done=%b rdata=%h expected %0d/%b/%h", t,
                                   n, bus.done, bus.rdata, master_len + 1, 4'b0001 << order[t], exp_rdata);
            end
            model_rdata = exp_rdata;
        end
        bus.req = '0;
        repeat (GAP + 3) @(negedge clk);
    endtask

    task automatic test_random();
        int n;
        int e;
        logic [3:0] mask;
        logic [15:0] latched;
        logic [7:0] exp_rdata;
        randomize_fields();
        drive_fields();
        mask = 4'($urandom_range(1, 15));
        bus.req = mask;
        for (int it = 0; it < 12; it++) begin
            master_len   = $urandom_range(3, 12);
            master_rdata = 8'($urandom);
            wait_gnt(100, n);
            e = rr_pick(model_last, mask);
            checks++;
            if (n !== ((it == 0) ? 2 : GAP + 3) || bus.gnt !== (4'b0001 << e)) begin
                errors++; $display("FAIL random_gnt[%0d]: got n=%0d gnt=%b mask=%b expected %0d/%b", it, n,
                                   bus.gnt, mask, (it == 0) ? 2 : GAP + 3, 4'b0001 << e);
            end
            latched    = {f_addr[e], f_rw[e], f_wdata[e]};
            model_last = e;
            exp_rdata  = f_rw[e] ? master_rdata : model_rdata;
            @(negedge clk);
            if ($urandom_range(0, 1) == 1) mask = mask & ~(4'b0001 << e);
            randomize_fields();
            drive_fields();
            bus.req = mask;
            @(negedge clk);
            checks++;
            if ({bus.m_addr, bus.m_rw, bus.m_data_in} !== latched) begin
                errors++; $display("FAIL random_latched[%0d]: got %h expected %h", it,
                                   {bus.m_addr, bus.m_rw, bus.m_data_in}, latched);
            end
            wait_done(100, n);
            checks++;
            if (bus.done !== (4'b0001 << e) || bus.err !== 4'b0000 || bus.rdata !== exp_rdata) begin
                errors++; $display("FAIL random_done[%0d]: got done=%b err=%b rdata=%h expected %b/0000/%h", it,
                                   bus.done, bus.err, bus.rdata, 4'b0001 << e, exp_rdata);
            end
            model_rdata = exp_rdata;
            mask = 4'($urandom_range(1, 15));
            bus.req = mask;
        end
        bus.req = '0;
        repeat (GAP + 4) @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        bit bad;
        master_dead = 1'b1;
        bus.req = 4'b0001;
        wait_gnt(20, n);
        checks++;
        if (bus.gnt !== (4'b0001 << rr_pick(model_last, 4'b0001))) begin
            errors++; $display("FAIL timeout_gnt: got %b expected 0001", bus.gnt);
        end
        model_last = 0;
        bad = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.err === 4'b0000 && (bus.done !== 4'b0000 || bus.m_enable !== 1'b1)) bad = 1'b1;
        end while (bus.err === 4'b0000 && n < 1500);
        // Counter runs 0..TIMEOUT-1 over LAUNCH cycles; the abort registers on the last one.
        checks++;
        if (n !== TIMEOUT) begin
            errors++; $display("FAIL timeout_latency: got %0d expected %0d", n, TIMEOUT);
        end
        checks++;
        if (bus.err !== 4'b0001 || bus.done !== 4'b0000 || bus.gnt !== 4'b0000 || bus.m_enable !== 1'b0) begin
            errors++; $display("FAIL timeout_abort: got err=%b done=%b gnt=%b en=%b expected 0001/0000/0000/0",
                               bus.err, bus.done, bus.gnt, bus.m_enable);
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL timeout_hold: got early done or enable drop, expected none");
        end
        bus.req = '0;
        @(negedge clk);
        checks++;
        if (bus.err !== 4'b0000 || bus.done !== 4'b0000) begin
            errors++; $display("FAIL timeout_pulse_width: got err=%b done=%b expected 0000/0000", bus.err, bus.done);
        end
        master_dead = 1'b0;
        repeat (GAP + 3) @(negedge clk);
    endtask

    task automatic test_bus_busy_reset();
        int n;
        bit bad;
        bus.bus_busy = 1'b1;
        bus.req = 4'b0010;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.gnt !== 4'b0000 || bus.m_lines_busy !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL busy_blocks_grant: got grant or lines idle, expected blocked");
        end
        master_len = 30;
        bus.bus_busy = 1'b0;
        wait_gnt(20, n);
        checks++;
        if (n !== 2 || bus.gnt !== 4'b0010) begin
            errors++; $display("FAIL busy_release_gnt: got n=%0d gnt=%b expected 2/0010", n, bus.gnt);
        end
        n = 0;
        while (bus.m_enable !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.gnt !== 4'b0000 || bus.m_enable !== 1'b0 || bus.done !== 4'b0000 || bus.err !== 4'b0000) begin
            errors++; $display("FAIL async_reset_outputs: got gnt=%b en=%b done=%b err=%b expected all 0",
                               bus.gnt, bus.m_enable, bus.done, bus.err);
        end
        checks++;
        if ({bus.m_addr, bus.m_rw, bus.m_data_in} !== 16'h0000 || bus.rdata !== 8'h00) begin
            errors++; $display("FAIL async_reset_fields: got %h rdata=%h expected 0000/00",
                               {bus.m_addr, bus.m_rw, bus.m_data_in}, bus.rdata);
        end
        bus.req = '0;
        @(negedge clk);
        rst = 1'b0;
        model_last  = 3;
        model_rdata = 8'h00;
        bad = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (bus.gnt !== 4'b0000 || bus.done !== 4'b0000 || bus.err !== 4'b0000) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL reset_no_pulse: got a grant/done/err after reset, expected none");
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_req_drop();
        test_read();
        test_contention();
        test_random();
        test_timeout();
        test_bus_busy_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
